// File: rtl/uart_tx_drain.sv
// Drains words from a synchronous FIFO and serializes them onto a UART line.
// Optional even-parity bit is compiled in when PARITY_EN is defined.
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef PARITY_EN
  logic                  par_q, par_d;
`endif

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          rd_d    = 1'b1;
          state_d = FETCH;
        end
      end
      // FIFO samples the read at the end of this cycle; data shows up in LOAD.
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
`ifdef PARITY_EN
        par_d   = ^fifo_data;
`endif
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_last) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Registered pulse: armed one cycle early so it lands on the last STOP cycle.
        done_d = (cnt_q == CNT_PRE);
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Drain stage that sits directly downstream of the team's synchronous byte FIFO. It pulls one word at a time through the FIFO read port and serializes it onto a UART line: 1 start bit, DATA_WIDTH data bits LSB-first, an optional even-parity bit and 1 stop bit. It owns the read-side handshake completely, including the FIFO's one-cycle read latency and its registered, lagging empty flag.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO.
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥ 2. The baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
- Reset rst, asynchronous, active-high; clock clk.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tx_en  in  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag; registered, may lag the true state by one cycle.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after the FIFO samples a read.
- fifo_rd_en  out  1  registered read strobe, one-cycle pulse per frame.
- tx  out  1  serial line; idles high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE: tx=1. If tx_en && !fifo_empty, set fifo_rd_en<=1 and go to FETCH. Otherwise stay.
- FETCH: fifo_rd_en<=0. The FIFO samples the read at the end of this cycle. Go to LOAD.
- LOAD: fifo_data is valid. Capture it into the shift register, tx<=0, clear the baud counter and go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA with bit index 0.
- DATA: each bit is held CLKS_PER_BIT cycles, shifting LSB-first. After bit DATA_WIDTH-1, go to PARITY if compiled in, else to STOP with tx<=1.
- PARITY: drive the XOR of all captured data bits for CLKS_PER_BIT cycles, then go to STOP with tx<=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. On the final cycle, pulse frame_done, then return to IDLE.
- The block never issues fifo_rd_en outside IDLE, so at most one read is outstanding.
- The frame length, FETCH/LOAD included, guarantees that fifo_empty has settled before IDLE samples it again. The lagging empty flag therefore cannot cause a read of an empty FIFO.
- tx_en deasserted mid-frame: the current frame completes normally, and no new frame starts.
- fifo_data changes outside LOAD are ignored.

## Timing
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, counters 0. These take effect immediately on rst, independent of clk.
- Reset mid-frame aborts the frame, returns tx high at once, and loses the word in flight. No read is issued until rst deasserts and the FSM re-enters IDLE.
- Latency: condition sampled true at edge N gives fifo_rd_en high during N..N+1 and tx falling at edge N+2.
- Frame length from the tx falling edge to the frame_done pulse: (2+DATA_WIDTH)·CLKS_PER_BIT cycles, plus CLKS_PER_BIT more with PARITY_EN.
- frame_done is high during the last STOP cycle. The next fifo_rd_en can rise at the earliest 1 cycle after IDLE is re-entered.
- Back-to-back frames, FIFO non-empty and tx_en held high: the tx falling edges are exactly frame_length+3 cycles apart.
- busy rises the cycle after the IDLE decision and falls together with the IDLE re-entry.

## Configuration
- PARITY_EN defined: the PARITY state is compiled in and one even-parity bit is inserted between the data bits and the stop bit.
- PARITY_EN undefined: the PARITY state and the parity logic are absent, and the frame is start + data + stop.

## Test plan
- Reset: hold rst with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, no read strobes; release -> first fifo_rd_en 1 cycle later.
- Single byte: FIFO holds 0xA5, CLKS_PER_BIT=4 -> exactly one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; frame_done pulses once; one frame spans 40 cycles.
- Parity, with PARITY_EN: byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame spans 44 cycles at CLKS_PER_BIT=4.
- Drain to empty: push 0x01, 0x02, 0x03 -> three frames with tx falling edges 43 cycles apart at CLKS_PER_BIT=4; exactly three reads; no fourth strobe after empty.
- tx_en gating: drop tx_en mid-frame -> the frame completes and busy falls; no read while tx_en=0; raise tx_en -> next read strobe 1 cycle later.
- Mid-frame reset: assert rst during DATA -> tx=1 combinationally; after release and with FIFO non-empty, the next frame carries the next FIFO word.
